// File: rtl/mdu_pkg.sv
// Shared types and op-decode helpers for the iterative multiply/divide unit.
// Optional build macro MDU_DIV_FAST_EN is consumed in mdu_iter.sv.
package mdu_pkg;

    localparam int MDU_OP_W = 4;

    // Encodings 13..15 are undefined and complete with a zero result.
    typedef enum logic [MDU_OP_W-1:0] {
        MDU_MUL    = 4'd0,
        MDU_MULH   = 4'd1,
        MDU_MULHSU = 4'd2,
        MDU_MULHU  = 4'd3,
        MDU_DIV    = 4'd4,
        MDU_DIVU   = 4'd5,
        MDU_REM    = 4'd6,
        MDU_REMU   = 4'd7,
        MDU_MULW   = 4'd8,
        MDU_DIVW   = 4'd9,
        MDU_DIVUW  = 4'd10,
        MDU_REMW   = 4'd11,
        MDU_REMUW  = 4'd12
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    function automatic logic is_defined(input mdu_op_e op);
        return op <= MDU_REMUW;
    endfunction

    function automatic logic is_div(input mdu_op_e op);
        return op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU,
                          MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW};
    endfunction

    function automatic logic is_rem(input mdu_op_e op);
        return op inside {MDU_REM, MDU_REMU, MDU_REMW, MDU_REMUW};
    endfunction

    function automatic logic is_mul_hi(input mdu_op_e op);
        return op inside {MDU_MULH, MDU_MULHSU, MDU_MULHU};
    endfunction

    function automatic logic is_word(input mdu_op_e op);
        return op inside {MDU_MULW, MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW};
    endfunction

    function automatic logic is_signed1(input mdu_op_e op);
        return op inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM, MDU_DIVW, MDU_REMW};
    endfunction

    function automatic logic is_signed2(input mdu_op_e op);
        return op inside {MDU_MULH, MDU_DIV, MDU_REM, MDU_DIVW, MDU_REMW};
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply (right shift) or restoring
// division (left shift), selected by div. Purely combinational.
module mdu_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] acc,
    input  logic [XLEN-1:0] sh,
    input  logic [XLEN-1:0] opnd,
    input  logic            div,
    output logic [XLEN-1:0] acc_nxt,
    output logic [XLEN-1:0] sh_nxt
);

    logic [XLEN:0] sum;
    logic [XLEN:0] part;
    logic [XLEN:0] shifted;
    logic          ge;

    always_comb begin
        sum     = {1'b0, acc} + {1'b0, opnd};
        part    = sh[0] ? sum : {1'b0, acc};
        shifted = {acc, sh[XLEN-1]};
        ge      = shifted >= {1'b0, opnd};
        acc_nxt = part[XLEN:1];
        sh_nxt  = {part[0], sh[XLEN-1:1]};
        if (div) begin
            // Remainder stays below the divisor, so XLEN bits always hold it.
            acc_nxt = ge ? (shifted[XLEN-1:0] - opnd) : shifted[XLEN-1:0];
            sh_nxt  = {sh[XLEN-2:0], ge};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M/RV64M multiply/divide unit with flush and tag pass-through.
// Define MDU_DIV_FAST_EN to skip the iterations for divide-by-zero/overflow.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  mdu_op_e          i_op,
    input  logic [XLEN-1:0]  i_src1,
    input  logic [XLEN-1:0]  i_src2,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_res,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_busy,
    output mdu_state_e       o_state
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    mdu_state_e       state_q, state_d, start_st;
    mdu_op_e          op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  acc_q, sh_q, opnd_q, src1_q, res_q;
    logic [TAG_W-1:0] tag_q;
    logic             s1n_q, s2n_q, dz_q, ovf_q;
    logic             accept;

    logic             in_word, in_def, in_n1, in_n2, in_dz, in_ovf;
    logic [XLEN-1:0]  in_mask, in_min, in_a, in_b, in_a_abs, in_b_abs;

    logic             op_div, w_q;
    logic [XLEN-1:0]  acc_nxt, sh_nxt;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]  quo, quo_s, rem_s, dres, fix_res;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        sext32       = {XLEN{v[31]}};
        sext32[31:0] = v;
    endfunction

    // Operand preparation on the accept edge: mask W ops to 32 bits, take
    // magnitudes of signed operands, flag the architectural corner cases.
    always_comb begin
        in_word  = is_word(i_op) && (XLEN == 64);
        in_def   = is_defined(i_op) && ((XLEN == 64) || !is_word(i_op));
        in_mask  = in_word ? XLEN'(32'hFFFF_FFFF) : '1;
        in_min   = in_word ? XLEN'(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        in_a     = i_src1 & in_mask;
        in_b     = i_src2 & in_mask;
        in_n1    = is_signed1(i_op) && (in_word ? i_src1[31] : i_src1[XLEN-1]);
        in_n2    = is_signed2(i_op) && (in_word ? i_src2[31] : i_src2[XLEN-1]);
        in_a_abs = in_n1 ? ((-in_a) & in_mask) : in_a;
        in_b_abs = in_n2 ? ((-in_b) & in_mask) : in_b;
        in_dz    = (in_b == '0);
        in_ovf   = is_div(i_op) && is_signed2(i_op) && (in_a == in_min) && (in_b == in_mask);
        start_st = in_def ? ST_CALC : ST_FIX;
`ifdef MDU_DIV_FAST_EN
        if (in_def && is_div(i_op) && (in_dz || in_ovf)) start_st = ST_FIX;
`else
        start_st = in_def ? ST_CALC : ST_FIX;
`endif
    end

    always_comb begin
        o_ready = !i_flush && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && i_ready));
        accept  = i_valid && o_ready;
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = start_st;
            ST_CALC: if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: if (i_ready) state_d = accept ? start_st : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (i_flush) state_d = ST_IDLE;
    end

    assign op_div = is_div(op_q);

    mdu_step #(.XLEN(XLEN)) u_step (
        .acc     (acc_q),
        .sh      (sh_q),
        .opnd    (opnd_q),
        .div     (op_div),
        .acc_nxt (acc_nxt),
        .sh_nxt  (sh_nxt)
    );

    // Result selection: sign correction first, then RISC-V corner overrides.
    always_comb begin
        w_q     = is_word(op_q);
        prod    = {acc_q, sh_q};
        prod_s  = (s1n_q ^ s2n_q) ? -prod : prod;
        quo     = w_q ? (sh_q & XLEN'(32'hFFFF_FFFF)) : sh_q;
        quo_s   = (s1n_q ^ s2n_q) ? -quo : quo;
        rem_s   = s1n_q ? -acc_q : acc_q;
        if (is_rem(op_q)) dres = dz_q ? src1_q : (ovf_q ? '0 : rem_s);
        else              dres = dz_q ? '1 : (ovf_q ? src1_q : quo_s);
        fix_res = '0;
        if (!is_defined(op_q) || (w_q && (XLEN != 64))) fix_res = '0;
        else if (op_q == MDU_MUL)  fix_res = prod_s[XLEN-1:0];
        else if (is_mul_hi(op_q))  fix_res = prod_s[2*XLEN-1:XLEN];
        else if (op_q == MDU_MULW) fix_res = sext32(sh_q[XLEN-1 -: 32]);
        else if (w_q)              fix_res = sext32(dres[31:0]);
        else                       fix_res = dres;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= MDU_MUL;
            tag_q   <= '0;
            acc_q   <= '0;
            sh_q    <= '0;
            opnd_q  <= '0;
            src1_q  <= '0;
            res_q   <= '0;
            s1n_q   <= 1'b0;
            s2n_q   <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= i_op;
                tag_q  <= i_tag;
                src1_q <= i_src1;
                s1n_q  <= in_n1;
                s2n_q  <= in_n2;
                dz_q   <= in_dz;
                ovf_q  <= in_ovf;
                acc_q  <= '0;
                // Divides shift the dividend out of the top; W dividends start at bit 63.
                sh_q   <= is_div(i_op) ? (in_word ? (in_a_abs << 32) : in_a_abs) : in_b_abs;
                opnd_q <= is_div(i_op) ? in_b_abs : in_a_abs;
                cnt_q  <= in_word ? CNT_W'(32) : CNT_W'(XLEN);
            end else if (state_q == ST_CALC) begin
                acc_q <= acc_nxt;
                sh_q  <= sh_nxt;
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if ((state_q == ST_FIX) && !i_flush) res_q <= fix_res;
        end
    end

    assign o_valid = (state_q == ST_DONE);
    assign o_busy  = (state_q != ST_IDLE);
    assign o_res   = res_q;
    assign o_tag   = tag_q;
    assign o_state = state_q;

endmodule
